calc_display_ctrl: RTL and testbench

CALC_DISPLAY_CTRL -- requirements
Module: calc_display_ctrl

---
 rtl/calc_disp_pkg.sv | 41 ++++
 rtl/calc_display_ctrl_if.sv | 22 ++
 rtl/seg7_decoder.sv | 26 ++
 rtl/calc_display_ctrl.sv | 161 ++++++++++++++++
 tb/tb_calc_display_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/calc_disp_pkg.sv
// Shared types and constants for the calculator display controller:
// FSM states, phase lengths, segment codes and the BCD add-3 helper.
package calc_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int SUM_CYCLES  = 1;
  localparam int MUL_CYCLES  = 4;
  localparam int CONV_CYCLES = 8;

  // Active-low segments, bit6 = a ... bit0 = g
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;

  // Any non-decimal code decodes to a blank digit
  localparam logic [3:0] BCD_BLANK = 4'hF;

  function automatic logic [11:0] bcd_adjust(input logic [11:0] bcd);
    logic [11:0] r;
    r = bcd;
    for (int i = 0; i < 3; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/calc_display_ctrl_if.sv
// Request/result bundle between a host and calc_display_ctrl, including the display pins.
interface calc_display_ctrl_if;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       selector;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [6:0] seg;
  logic [2:0] an;

  modport master (
    output start, a, b, selector,
    input  busy, done, result, seg, an
  );

  modport slave (
    input  start, a, b, selector,
    output busy, done, result, seg, an
  );
endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment code; non-decimal inputs blank.
module seg7_decoder
  import calc_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/calc_display_ctrl.sv
// 4-bit add/multiply with double-dabble BCD conversion and a free-running 3-digit scan.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits on the display.
module calc_display_ctrl
  import calc_disp_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic                clk,
  input  logic                rst,
  calc_display_ctrl_if.slave  bus
);

  localparam int SCAN_W = $clog2(SCAN_DIV);

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [7:0]          mcand_q, mcand_d;
  logic [3:0]          mplier_q, mplier_d;
  logic                sel_q, sel_d;
  logic [7:0]          acc_q, acc_d;
  logic [19:0]         shreg_q, shreg_d;
  logic [7:0]          result_q, result_d;
  logic [11:0]         digits_q, digits_d;
  logic [SCAN_W-1:0]   scan_q, scan_d;
  logic [1:0]          idx_q, idx_d;

  logic [2:0]          calc_last;
  logic                hund_blank, tens_blank;
  logic [3:0]          disp_bcd;
  logic [2:0]          an_c;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    sel_d     = sel_q;
    acc_d     = acc_q;
    shreg_d   = shreg_q;
    result_d  = result_q;
    digits_d  = digits_q;
    calc_last = sel_q ? 3'(MUL_CYCLES - 1) : 3'(SUM_CYCLES - 1);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = {4'b0, bus.a};
          mplier_d = bus.b;
          sel_d    = bus.selector;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (!sel_q) begin
          acc_d = mcand_q + {4'b0, mplier_q};
        end else begin
          // Shift-add: consume one multiplier bit per cycle, LSB first
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == calc_last) begin
          cnt_d   = '0;
          shreg_d = {12'b0, acc_d};
          state_d = CONV;
        end
      end
      CONV: begin
        shreg_d = {bcd_adjust(shreg_q[19:8]), shreg_q[7:0]} << 1;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'(CONV_CYCLES - 1)) begin
          // Result and digits change together on the edge into DONE
          cnt_d    = '0;
          result_d = acc_q;
          digits_d = shreg_d[19:8];
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    scan_d = scan_q + SCAN_W'(1);
    idx_d  = idx_q;
    if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sel_q    <= 1'b0;
      acc_q    <= '0;
      shreg_q  <= '0;
      result_q <= '0;
      digits_q <= '0;
      scan_q   <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sel_q    <= sel_d;
      acc_q    <= acc_d;
      shreg_q  <= shreg_d;
      result_q <= result_d;
      digits_q <= digits_d;
      scan_q   <= scan_d;
      idx_q    <= idx_d;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign hund_blank = (digits_q[11:8] == 4'd0);
  assign tens_blank = hund_blank && (digits_q[7:4] == 4'd0);
`else
  assign hund_blank = 1'b0;
  assign tens_blank = 1'b0;
`endif

  always_comb begin
    an_c     = 3'b110;
    disp_bcd = digits_q[3:0];
    case (idx_q)
      2'd1: begin
        an_c     = 3'b101;
        disp_bcd = tens_blank ? BCD_BLANK : digits_q[7:4];
      end
      2'd2: begin
        an_c     = 3'b011;
        disp_bcd = hund_blank ? BCD_BLANK : digits_q[11:8];
      end
      default: begin
        an_c     = 3'b110;
        disp_bcd = digits_q[3:0];
      end
    endcase
  end

  seg7_decoder u_seg7_decoder (
    .bcd (disp_bcd),
    .seg (bus.seg)
  );

  assign bus.an     = an_c;
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;

endmodule

// File: tb/tb_calc_display_ctrl.sv
// Directed bench for calc_display_ctrl with SCAN_DIV=4 and hand-computed expectations.
module tb_calc_display_ctrl;

  localparam int SCAN_DIV = 4;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'b1111111;
`else
  localparam logic [6:0] LZ_SEG = 7'b0000001;
`endif

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  calc_display_ctrl_if bus ();

  calc_display_ctrl #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Launch one operation; the first edge after this call is the sampling edge.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic sel,
                        input int exp_edges, input logic [7:0] exp_res,
                        input logic [7:0] prev_res);
    int edges;
    edges        = -1;
    bus.start    = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.selector = sel;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (k == 0) begin
        bus.start    = 1'b0;
        bus.a        = ~a;
        bus.b        = ~b;
        bus.selector = ~sel;
        check("busy_after_sample", bus.busy, 1);
      end
      if (k == 3) check("result_hold", bus.result, prev_res);
      if (bus.done) begin
        edges = k;
        break;
      end
    end
    check("done_edge", edges, exp_edges);
    check("result", bus.result, exp_res);
    tick();
    check("done_pulse_width", bus.done, 0);
    check("busy_back_idle", bus.busy, 0);
  endtask

  task automatic check_digits(input logic [6:0] exp_h, input logic [6:0] exp_t,
                              input logic [6:0] exp_o);
    logic [6:0] sh, st, so;
    sh = 7'h55;
    st = 7'h55;
    so = 7'h55;
    for (int k = 0; k < 3 * SCAN_DIV + 1; k++) begin
      case (bus.an)
        3'b110:  so = bus.seg;
        3'b101:  st = bus.seg;
        3'b011:  sh = bus.seg;
        default: check("an_onehot", bus.an, 3'b110);
      endcase
      tick();
    end
    check("seg_hundreds", sh, exp_h);
    check("seg_tens", st, exp_t);
    check("seg_ones", so, exp_o);
  endtask

  initial begin
    int first_k, second_k, n_done;
    logic busy13, busy14, found;
    logic [7:0] r1, r2;
    logic [2:0] prev_an;

    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.selector = 1'b0;
    tick(3);

    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_an", bus.an, 3'b110);
    check("rst_seg", bus.seg, 7'b0000001);

    // Reset wins over a simultaneous start
    bus.start = 1'b1;
    bus.a     = 4'd3;
    bus.b     = 4'd3;
    tick();
    check("rst_over_start", bus.busy, 0);
    bus.start = 1'b0;
    rst       = 1'b0;
    tick();

    run_op(4'd7, 4'd9, 1'b1, 12, 8'd63, 8'd0);
    check_digits(LZ_SEG, 7'b0100000, 7'b0000110);

    run_op(4'd15, 4'd15, 1'b0, 9, 8'd30, 8'd63);
    check_digits(LZ_SEG, 7'b0000110, 7'b0000001);

    run_op(4'd15, 4'd15, 1'b1, 12, 8'd225, 8'd30);
    check_digits(7'b0010010, 7'b0010010, 7'b0100100);

    // Start held for 20 edges with operands changing mid-operation
    first_k      = -1;
    second_k     = -1;
    n_done       = 0;
    busy13       = 1'bx;
    busy14       = 1'bx;
    r1           = 'x;
    r2           = 'x;
    bus.start    = 1'b1;
    bus.a        = 4'd3;
    bus.b        = 4'd4;
    bus.selector = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (k == 5) begin
        bus.a        = 4'd5;
        bus.b        = 4'd5;
        bus.selector = 1'b0;
      end
      if (k == 19) bus.start = 1'b0;
      if (k == 13) busy13 = bus.busy;
      if (k == 14) busy14 = bus.busy;
      if (bus.done) begin
        n_done++;
        if (first_k < 0) begin
          first_k = k;
          r1      = bus.result;
        end else begin
          second_k = k;
          r2       = bus.result;
        end
      end
    end
    check("held_first_done", first_k, 12);
    check("held_first_result", r1, 8'd12);
    check("held_idle_gap", busy13, 0);
    check("held_resample", busy14, 1);
    check("held_second_done", second_k, 23);
    check("held_second_result", r2, 8'd10);
    check("held_done_count", n_done, 2);

    // Reset during the 4th CONV cycle of a sum
    n_done       = 0;
    bus.start    = 1'b1;
    bus.a        = 4'd2;
    bus.b        = 4'd3;
    bus.selector = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (bus.done) n_done++;
    end
    rst = 1'b1;
    tick();
    check("abort_done", bus.done, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_result", bus.result, 0);
    check("abort_an", bus.an, 3'b110);
    check("abort_seg", bus.seg, 7'b0000001);
    rst = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus.done) n_done++;
    end
    check("abort_no_done", n_done, 0);

    // Scan sequence with 105 on display
    run_op(4'd15, 4'd7, 1'b1, 12, 8'd105, 8'd0);
    found   = 1'b0;
    prev_an = bus.an;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (prev_an == 3'b011 && bus.an == 3'b110) begin
        found = 1'b1;
        break;
      end
      prev_an = bus.an;
    end
    check("scan_sync", found, 1);
    check("scan_ones_an", bus.an, 3'b110);
    check("scan_ones_seg", bus.seg, 7'b0100100);
    tick(3);
    check("scan_ones_hold", bus.an, 3'b110);
    tick();
    check("scan_tens_an", bus.an, 3'b101);
    check("scan_tens_seg", bus.seg, 7'b0000001);
    tick(4);
    check("scan_hund_an", bus.an, 3'b011);
    check("scan_hund_seg", bus.seg, 7'b1001111);
    tick(4);
    check("scan_wrap_an", bus.an, 3'b110);
    check("scan_wrap_seg", bus.seg, 7'b0100100);

    run_op(4'd2, 4'd3, 1'b0, 9, 8'd5, 8'd105);
    check_digits(LZ_SEG, LZ_SEG, 7'b0100100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
